// File: rtl/vga_timing_pipe_if.sv
// vga_timing_pipe_if
//   Bundles every signal between the VGA timing generator and the logic around it:
//   the run enable, the request-stage position and strobes sent to the pixel source,
//   the RGB coming back from that source, and the delayed pin-side outputs.
//   master : the timing generator (vga_timing_pipe)
//   slave  : the pixel source / board side
//   Parameters HPOS_W / VPOS_W / COLOR_BITS must match the generator's derived widths.
interface vga_timing_pipe_if #(
  parameter int HPOS_W     = 10,
  parameter int VPOS_W     = 10,
  parameter int COLOR_BITS = 2
);
  logic                    ena;
  logic [HPOS_W-1:0]       hpos;
  logic [VPOS_W-1:0]       vpos;
  logic                    active;
  logic                    line_start;
  logic                    frame_start;
  logic [3*COLOR_BITS-1:0] rgb_in;
  logic                    de_out;
  logic                    hsync_out;
  logic                    vsync_out;
  logic [7:0]              uo_out;
  logic [15:0]             frame_crc;
  logic                    crc_valid;

  modport master (
    input  ena, rgb_in,
    output hpos, vpos, active, line_start, frame_start,
           de_out, hsync_out, vsync_out, uo_out, frame_crc, crc_valid
  );

  modport slave (
    output ena, rgb_in,
    input  hpos, vpos, active, line_start, frame_start,
           de_out, hsync_out, vsync_out, uo_out, frame_crc, crc_valid
  );
endinterface

// File: rtl/vga_timing_pipe.sv
// vga_timing_pipe
//   Parametrised VGA timing generator with a pixel output stage aligned to a
//   pixel source of PIPE_DEPTH cycles latency, packed for the TT VGA PMOD.
//   Ports:
//     clk    pixel clock
//     rst_n  asynchronous active-low reset
//     vga    vga_timing_pipe_if.master:
//              ena in; hpos/vpos/active/line_start/frame_start out (request stage);
//              rgb_in in ({r,g,b}, valid PIPE_DEPTH cycles after its hpos/vpos);
//              de_out/hsync_out/vsync_out/uo_out out (PIPE_DEPTH+1 cycles after hpos);
//              frame_crc/crc_valid out.
//   Optional feature: define VGA_FRAME_CRC_EN to build the per-frame CRC-16-CCITT
//   over the displayed pixels; otherwise frame_crc/crc_valid are tied to zero.
module vga_timing_pipe #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int PIPE_DEPTH = 2,
  parameter int COLOR_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vga_timing_pipe_if.master     vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HPOS_W  = $clog2(H_TOTAL);
  localparam int VPOS_W  = $clog2(V_TOTAL);

  localparam logic [HPOS_W-1:0] H_LAST   = HPOS_W'(H_TOTAL - 1);
  localparam logic [HPOS_W-1:0] H_ACT_N  = HPOS_W'(H_ACTIVE);
  localparam logic [HPOS_W-1:0] HS_BEG   = HPOS_W'(H_ACTIVE + H_FRONT);
  localparam logic [HPOS_W-1:0] HS_END   = HPOS_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VPOS_W-1:0] V_LAST   = VPOS_W'(V_TOTAL - 1);
  localparam logic [VPOS_W-1:0] V_ACT_N  = VPOS_W'(V_ACTIVE);
  localparam logic [VPOS_W-1:0] VS_BEG   = VPOS_W'(V_ACTIVE + V_FRONT);
  localparam logic [VPOS_W-1:0] VS_END   = VPOS_W'(V_ACTIVE + V_FRONT + V_SYNC);

  if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_timing
    $error("vga_timing_pipe: every timing parameter must be non-zero");
  end
  if (PIPE_DEPTH < 1 || PIPE_DEPTH > 8) begin : g_bad_depth
    $error("vga_timing_pipe: PIPE_DEPTH must be in 1..8");
  end
  if (COLOR_BITS < 2) begin : g_bad_color
    $error("vga_timing_pipe: COLOR_BITS must be at least 2");
  end

  logic [HPOS_W-1:0] hpos_q, hpos_d;
  logic [VPOS_W-1:0] vpos_q, vpos_d;
  logic              req_act, req_hs, req_vs;

  always_comb begin
    hpos_d = hpos_q;
    vpos_d = vpos_q;
    if (vga.ena) begin
      if (hpos_q == H_LAST) begin
        hpos_d = '0;
        vpos_d = (vpos_q == V_LAST) ? '0 : vpos_q + VPOS_W'(1);
      end else begin
        hpos_d = hpos_q + HPOS_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_q <= '0;
      vpos_q <= '0;
    end else begin
      hpos_q <= hpos_d;
      vpos_q <= vpos_d;
    end
  end

  // Request stage. Strobes are qualified by rst_n so they read 0 while reset is held.
  assign req_act = rst_n && vga.ena && (hpos_q < H_ACT_N) && (vpos_q < V_ACT_N);
  assign req_hs  = vga.ena && (hpos_q >= HS_BEG) && (hpos_q < HS_END);
  assign req_vs  = vga.ena && (vpos_q >= VS_BEG) && (vpos_q < VS_END);

  assign vga.hpos        = hpos_q;
  assign vga.vpos        = vpos_q;
  assign vga.active      = req_act;
  assign vga.line_start  = rst_n && vga.ena && (hpos_q == '0);
  assign vga.frame_start = rst_n && vga.ena && (hpos_q == '0) && (vpos_q == '0);

  // Delay line: bit 0 is the newest entry, bit PIPE_DEPTH-1 lines up with rgb_in.
  logic [PIPE_DEPTH-1:0] act_pipe_q, hs_pipe_q, vs_pipe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_pipe_q <= '0;
      hs_pipe_q  <= '0;
      vs_pipe_q  <= '0;
    end else begin
      act_pipe_q <= (act_pipe_q << 1) | PIPE_DEPTH'(req_act);
      hs_pipe_q  <= (hs_pipe_q  << 1) | PIPE_DEPTH'(req_hs);
      vs_pipe_q  <= (vs_pipe_q  << 1) | PIPE_DEPTH'(req_vs);
    end
  end

  // Output stage: only the top two bits per channel reach the PMOD.
  logic       de_q, hs_q, vs_q;
  logic [5:0] rgb_q;   // {r1,r0,g1,g0,b1,b0}
  logic [5:0] rgb_top;

  assign rgb_top = {vga.rgb_in[3*COLOR_BITS-1 -: 2],
                    vga.rgb_in[2*COLOR_BITS-1 -: 2],
                    vga.rgb_in[COLOR_BITS-1   -: 2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q  <= 1'b0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      rgb_q <= '0;
    end else begin
      de_q  <= act_pipe_q[PIPE_DEPTH-1];
      hs_q  <= hs_pipe_q[PIPE_DEPTH-1];
      vs_q  <= vs_pipe_q[PIPE_DEPTH-1];
      // Blanking is black whatever the pixel source presents.
      rgb_q <= act_pipe_q[PIPE_DEPTH-1] ? rgb_top : 6'd0;
    end
  end

  logic hs_pin, vs_pin;
  assign hs_pin        = HSYNC_POL ? hs_q : ~hs_q;
  assign vs_pin        = VSYNC_POL ? vs_q : ~vs_q;
  assign vga.de_out    = de_q;
  assign vga.hsync_out = hs_pin;
  assign vga.vsync_out = vs_pin;
  assign vga.uo_out    = {hs_pin, rgb_q[0], rgb_q[2], rgb_q[4],
                          vs_pin, rgb_q[1], rgb_q[3], rgb_q[5]};

`ifdef VGA_FRAME_CRC_EN
  // Marks the last visible pixel of the frame; travels with the pixel it belongs to.
  localparam logic [HPOS_W-1:0] H_ACT_LAST = HPOS_W'(H_ACTIVE - 1);
  localparam logic [VPOS_W-1:0] V_ACT_LAST = VPOS_W'(V_ACTIVE - 1);

  logic                  req_last;
  logic [PIPE_DEPTH-1:0] last_pipe_q;
  logic                  last_q;
  logic [15:0]           crc_q, frame_crc_q, crc_next;
  logic                  crc_valid_q;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      c = (c[15] ^ data[i]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
    end
    return c;
  endfunction

  assign req_last = req_act && (hpos_q == H_ACT_LAST) && (vpos_q == V_ACT_LAST);
  assign crc_next = crc16_byte(crc_q, {2'b00, rgb_q});

  // Accumulation follows de_out, so pixels already in flight when ena drops still count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_pipe_q <= '0;
      last_q      <= 1'b0;
      crc_q       <= 16'hFFFF;
      frame_crc_q <= 16'h0000;
      crc_valid_q <= 1'b0;
    end else begin
      last_pipe_q <= (last_pipe_q << 1) | PIPE_DEPTH'(req_last);
      last_q      <= last_pipe_q[PIPE_DEPTH-1];
      crc_valid_q <= 1'b0;
      if (de_q) begin
        if (last_q) begin
          frame_crc_q <= crc_next;
          crc_valid_q <= 1'b1;
          crc_q       <= 16'hFFFF;
        end else begin
          crc_q <= crc_next;
        end
      end
    end
  end

  assign vga.frame_crc = frame_crc_q;
  assign vga.crc_valid = crc_valid_q;
`else
  assign vga.frame_crc = 16'h0000;
  assign vga.crc_valid = 1'b0;
`endif
endmodule

// File: tb/tb_vga_timing_pipe.sv
module tb_vga_timing_pipe;
  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;  // 14
  localparam int VT = VA + VF + VS + VB;  // 7

  typedef struct {
    bit       de;
    bit       hs;
    bit       vs;
    bit       last;
    bit [5:0] rgb;
  } req_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vga_timing_pipe_if #(.HPOS_W(4), .VPOS_W(3), .COLOR_BITS(2)) vif();

  vga_timing_pipe #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE_DEPTH(2), .COLOR_BITS(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (vif)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  int       mh, mv;
  req_t     pinq[$];
  bit [5:0] rgbq[$];
  bit [5:0] col[HT][VT];
  bit [15:0] m_crc, m_fcrc;
  bit        m_valid;
  int        crc_events;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit [15:0] crc_ref(input bit [15:0] c, input bit [7:0] d);
    bit [15:0] r;
    bit fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[15] ^ d[7-i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  function automatic bit [7:0] pins(input bit hs_n, input bit vs_n, input bit [5:0] c);
    // c = {r1,r0,g1,g0,b1,b0}; pins = {hs, b0, g0, r0, vs, b1, g1, r1}
    return {hs_n, c[0], c[2], c[4], vs_n, c[1], c[3], c[5]};
  endfunction

  task automatic model_reset();
    req_t idle;
    idle = '{de: 1'b0, hs: 1'b0, vs: 1'b0, last: 1'b0, rgb: 6'd0};
    mh = 0;
    mv = 0;
    pinq.delete();
    rgbq.delete();
    for (int i = 0; i < 3; i++) pinq.push_back(idle);
    for (int i = 0; i < 2; i++) rgbq.push_back(6'd0);
    m_crc   = 16'hFFFF;
    m_fcrc  = 16'h0000;
    m_valid = 1'b0;
  endtask

  task automatic chk_reset_state();
    chk("rst_hpos",   32'(vif.hpos), 0);
    chk("rst_vpos",   32'(vif.vpos), 0);
    chk("rst_active", 32'(vif.active), 0);
    chk("rst_lstart", 32'(vif.line_start), 0);
    chk("rst_fstart", 32'(vif.frame_start), 0);
    chk("rst_de",     32'(vif.de_out), 0);
    chk("rst_hsync",  32'(vif.hsync_out), 1);
    chk("rst_vsync",  32'(vif.vsync_out), 1);
    chk("rst_uo",     32'(vif.uo_out), 32'h88);
    chk("rst_crc",    32'(vif.frame_crc), 0);
    chk("rst_crcv",   32'(vif.crc_valid), 0);
  endtask

  // One clock cycle; entered and left 1 time unit after a rising edge.
  task automatic tick(input bit e);
    req_t p, r;
    bit   act;
    vif.ena    = e;
    vif.rgb_in = rgbq[0];
    #1;
    act = e && (mh < HA) && (mv < VA);
    chk("hpos",   32'(vif.hpos), 32'(mh));
    chk("vpos",   32'(vif.vpos), 32'(mv));
    chk("active", 32'(vif.active), 32'(act));
    chk("lstart", 32'(vif.line_start), 32'(e && mh == 0));
    chk("fstart", 32'(vif.frame_start), 32'(e && mh == 0 && mv == 0));
    p = pinq[0];
    chk("de",     32'(vif.de_out), 32'(p.de));
    chk("hsync",  32'(vif.hsync_out), 32'(!p.hs));
    chk("vsync",  32'(vif.vsync_out), 32'(!p.vs));
    chk("uo",     32'(vif.uo_out), 32'(pins(!p.hs, !p.vs, p.rgb)));
`ifdef VGA_FRAME_CRC_EN
    chk("crcv",   32'(vif.crc_valid), 32'(m_valid));
    chk("crc",    32'(vif.frame_crc), 32'(m_fcrc));
    if (vif.crc_valid === 1'b1) crc_events++;
    m_valid = 1'b0;
    if (p.de) begin
      if (p.last) begin
        m_fcrc  = crc_ref(m_crc, {2'b00, p.rgb});
        m_crc   = 16'hFFFF;
        m_valid = 1'b1;
      end else begin
        m_crc = crc_ref(m_crc, {2'b00, p.rgb});
      end
    end
`else
    chk("crcv",   32'(vif.crc_valid), 0);
    chk("crc",    32'(vif.frame_crc), 0);
`endif
    r.de   = act;
    r.hs   = e && (mh >= HA + HF) && (mh < HA + HF + HS);
    r.vs   = e && (mv >= VA + VF) && (mv < VA + VF + VS);
    r.last = act && (mh == HA - 1) && (mv == VA - 1);
    r.rgb  = act ? col[mh][mv] : 6'd0;
    void'(pinq.pop_front());
    pinq.push_back(r);
    void'(rgbq.pop_front());
    rgbq.push_back(act ? r.rgb : 6'($urandom));
    @(posedge clk);
    #1;
    if (e) begin
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
  endtask

  initial begin
    bit [15:0] crc_const;
    crc_events = 0;
    for (int h = 0; h < HT; h++)
      for (int v = 0; v < VT; v++)
        col[h][v] = 6'($urandom);

    // Power-on reset with ena high: strobes must still read 0.
    rst_n      = 1'b0;
    vif.ena    = 1'b1;
    vif.rgb_in = 6'h3F;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state();
    model_reset();
    rst_n = 1'b1;

    // Two full frames free-running.
    repeat (2 * HT * VT) tick(1'b1);

    // Freeze at hpos=5, vpos=2 for 20 cycles, then resume.
    for (int i = 0; i < HT * VT && !(mh == 5 && mv == 2); i++) tick(1'b1);
    repeat (20) tick(1'b0);
    chk("hold_h", 32'(vif.hpos), 5);
    chk("hold_v", 32'(vif.vpos), 2);
    repeat (HT) tick(1'b1);

    // Random ena toggling.
    repeat (300) tick($urandom_range(0, 3) != 0);

    // Mid-line reset at hpos=7, vpos=1.
    for (int i = 0; i < HT * VT && !(mh == 1 + 6 && mv == 1); i++) tick(1'b1);
    rst_n = 1'b0;
    #1;
    chk_reset_state();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_reset_state();
    model_reset();
    rst_n = 1'b1;
    repeat (HT * VT + HT * 3) tick(1'b1);

    // Constant full-scale colour over whole frames.
    for (int i = 0; i < HT * VT && !(mh == 0 && mv == 0); i++) tick(1'b1);
    for (int h = 0; h < HT; h++)
      for (int v = 0; v < VT; v++)
        col[h][v] = 6'h3F;
    crc_events = 0;
    repeat (2 * HT * VT + 6) tick(1'b1);
    crc_const = 16'hFFFF;
    for (int i = 0; i < HA * VA; i++) crc_const = crc_ref(crc_const, 8'h3F);
`ifdef VGA_FRAME_CRC_EN
    chk("crc_const",  32'(vif.frame_crc), 32'(crc_const));
    chk("crc_events", 32'(crc_events), 2);
`else
    chk("crc_off",    32'(vif.frame_crc), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
